// File: rtl/apb_wait_slave.sv
// APB completer: byte-wide register bank with counter-driven PREADY wait states.
// Optional macro APB_SLV_ERR_EN drives PSLVERR for accesses to unmapped addresses.
module apb_wait_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  // state  | meaning
  // IDLE   | no transfer in flight; a PSEL & !PENABLE cycle seen here is the setup phase
  // ACCESS | access phase; r_cnt holds remaining wait cycles, ready when it reaches 0
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic          w_setup;
  logic          w_ready;
  logic          w_xfer;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  assign w_setup    = PSEL & ~PENABLE;
  assign w_ready    = (r_state == ST_ACCESS) && (r_cnt == 4'd0);
  assign w_xfer     = w_ready & PSEL & PENABLE;
  assign w_in_range = ({1'b0, PADDR} < 9'(DEPTH));
  assign w_idx      = PADDR[AW-1:0];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The setup phase is only visible through the inputs of the same cycle, so it is
  // recognised in IDLE and the counter is armed on the edge that ends it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = 4'(WAIT_STATES);
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (w_setup) begin
          w_cnt_nxt = 4'(WAIT_STATES);
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_xfer && PWRITE && w_in_range) begin
      r_mem[w_idx] <= PWDATA;
    end
  end

  assign PREADY = w_ready;
  assign PRDATA = (w_xfer && !PWRITE && w_in_range) ? r_mem[w_idx] : 8'h00;

`ifdef APB_SLV_ERR_EN
  assign PSLVERR = w_xfer & ~w_in_range;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB completer that sits directly downstream of the APB master bridge, on the same PSEL/PENABLE/PWRITE/PADDR[7:0]/PWDATA bus as the existing slaves.
- Contains a byte-wide register bank with DEPTH entries.
- Inserts a parameterised number of wait states through a counter-driven PREADY handshake.
- Flags accesses to unmapped addresses with PSLVERR.

Parameters:
- DEPTH, 64, number of 8-bit registers; addresses 0..DEPTH-1 are mapped; legal range 1..256.
- WAIT_STATES, 2, number of access-phase cycles with PREADY=0 before the ready cycle; legal range 0..15.

Ports:
- PCLK  input  1  bus clock; all state updates on rising edge.
- PRESETn  input  1  reset, asynchronous assert, active-low.
- PSEL  input  1  slave select from the master bridge.
- PENABLE  input  1  access-phase strobe.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  8  byte address.
- PWDATA  input  8  write data.
- PRDATA  output  8  read data.
- PREADY  output  1  transfer-complete handshake.
- PSLVERR  output  1  error response, valid only in the ready cycle.

Behaviour:
- Reset (PRESETn=0, asynchronous): state=IDLE, wait counter=0, all DEPTH registers=8'h00. Outputs during reset: PRDATA=0, PREADY=0, PSLVERR=0.
- FSM states and transitions:
  - IDLE: PSEL=1 & PENABLE=0 -> SETUP. PENABLE=1 without a prior setup cycle is ignored; stay in IDLE.
  - SETUP: load counter with WAIT_STATES. PSEL=1 & PENABLE=1 -> ACCESS. PSEL=0 -> IDLE. PSEL=1 & PENABLE=0 -> stay in SETUP and reload counter.
  - ACCESS:
    - counter!=0: PREADY=0 and counter decrements each cycle.
    - counter==0: PREADY=1 (ready cycle).
    - After the ready cycle: PSEL=1 & PENABLE=0 -> SETUP (back-to-back); otherwise -> IDLE.
  - Abort: PSEL=0 at any point in ACCESS -> IDLE. No write, no error, PREADY stays 0.
- Latency: access phase lasts WAIT_STATES+1 cycles. With WAIT_STATES=0, PREADY=1 in the first access cycle.
- Handshake signals:
  - PREADY is decoded combinationally from state and counter: 1 only in ACCESS with counter==0, 0 otherwise.
  - PADDR, PWRITE and PWDATA are sampled in the ready cycle; the master holds them stable from setup onward.
- Write: mem[PADDR] <= PWDATA on the rising edge ending the ready cycle, only if PWRITE=1 and PADDR<DEPTH.
- Read: PRDATA = mem[PADDR] during the ready cycle when PWRITE=0 and PADDR<DEPTH; PRDATA=0 at all other times.
- A read in the ready cycle following a write to the same address returns the new value; no bypass is needed because the write completes first.
- Out-of-range (PADDR>=DEPTH): no state change to the bank; PRDATA=0; error handling per APB_SLV_ERR_EN.
- Reset mid-transfer: immediate return to IDLE; the in-flight write is dropped; the bank is cleared.

Optional Feature:
- Macro: APB_SLV_ERR_EN.
- Defined: PSLVERR=1 in the ready cycle of any access with PADDR>=DEPTH; 0 otherwise.
- Not defined: PSLVERR tied to 0. Out-of-range writes are silently dropped; out-of-range reads return 8'h00.
- Wait-state timing is identical in both builds.

Test Plan:
- Reset then read addr 8'h05 (WAIT_STATES=2) -> PREADY low for 2 access cycles, high on the 3rd; PRDATA=8'h00; PSLVERR=0.
- Write 8'hA5 to 8'h10, then read 8'h10 -> read ready cycle shows PRDATA=8'hA5; each transfer takes 1 setup + 3 access cycles.
- Back-to-back writes 8'h11->8'h01 and 8'h22->8'h02 with no idle cycle between, then read both -> values 8'h11 and 8'h22; second setup starts the cycle after the first ready.
- Write 8'h3C to 8'h40 with DEPTH=64 -> ERR_EN build: PSLVERR=1 in the ready cycle; then read 8'h40 -> PRDATA=0, PSLVERR=1. Non-ERR_EN build: PSLVERR=0 throughout.
- Start write 8'hFF to 8'h07, drop PSEL after 1 wait cycle -> FSM back to IDLE, PREADY never asserted; subsequent read of 8'h07 returns the old value 8'h00.
- Assert PRESETn=0 mid-ACCESS after writing 8'h5A to 8'h03 -> PREADY=0 immediately; after reset, read 8'h03 returns 8'h00. Repeat with WAIT_STATES=0 -> PREADY=1 in the first access cycle.
